// File: rtl/pll_seq_pkg.sv
// Shared types and default constants for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } seq_state_e;

  localparam int unsigned DEF_RST_CYCLES          = 16;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int unsigned DEF_MAX_RETRIES         = 3;

  // Width of a counter that only has to reach n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the raw PLL lock flag into the inclk0 domain.
module pll_lock_sync (
  input  logic inclk0,
  input  logic reset,
  input  logic pll_locked,
  output logic lock_s
);

  logic meta;

  // NOTE: non-blocking assignments so each flop captures the previous stage's old value.
  always_ff @(posedge inclk0) begin
    if (reset) begin
      meta   <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      meta   <= pll_locked;
      lock_s <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer gating the audio-datapath reset on a stable lock.
// Optional: define PLL_SEQ_LOSS_COUNT_EN to add the saturating lock_loss_count port.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES          = DEF_RST_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic                               inclk0,
  input  logic                               reset,
  input  logic                               restart,
  input  logic                               pll_locked,
  output logic                               pll_areset,
  output logic                               sys_reset,
  output logic                               ready,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
`ifdef PLL_SEQ_LOSS_COUNT_EN
  ,
  output logic [7:0]                         lock_loss_count
`endif
);

  localparam int unsigned RW  = $clog2(MAX_RETRIES + 1);
  localparam int unsigned RCW = cnt_width(RST_CYCLES);
  localparam int unsigned SCW = cnt_width(LOCK_STABLE_CYCLES);
  localparam int unsigned TCW = cnt_width(LOCK_TIMEOUT_CYCLES);

  localparam logic [RW-1:0]  RETRY_MAX   = RW'(MAX_RETRIES);
  localparam logic [RCW-1:0] RST_LAST    = RCW'(RST_CYCLES - 1);
  localparam logic [SCW-1:0] STABLE_LAST = SCW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TCW-1:0] TO_LAST     = TCW'(LOCK_TIMEOUT_CYCLES - 1);

  seq_state_e      state, next_state;
  logic [RCW-1:0]  rst_cnt;
  logic [SCW-1:0]  stable_cnt;
  logic [TCW-1:0]  to_cnt;
  logic [RW-1:0]   retry_next;
  logic            lock_s;
  logic            pll_areset_d, sys_reset_d, ready_d, fault_d;

  pll_lock_sync u_sync (
    .inclk0     (inclk0),
    .reset      (reset),
    .pll_locked (pll_locked),
    .lock_s     (lock_s)
  );

  // NOTE: defaults first so every path assigns every comb output (no latch).
  always_comb begin
    next_state = state;
    retry_next = retry_count;
    if (restart) begin
      next_state = RESET_PLL;
      retry_next = '0;
    end else begin
      case (state)
        RESET_PLL: if (rst_cnt == RST_LAST) next_state = WAIT_LOCK;
        WAIT_LOCK: begin
          if (lock_s) begin
            next_state = STABLE;
          end else if (to_cnt == TO_LAST) begin
            if (retry_count < RETRY_MAX) begin
              next_state = RESET_PLL;
              retry_next = retry_count + 1'b1;
            end else begin
              next_state = FAULT;
            end
          end
        end
        STABLE: begin
          if (!lock_s)                         next_state = WAIT_LOCK;
          else if (stable_cnt == STABLE_LAST)  next_state = RUN;
        end
        RUN: begin
          if (!lock_s) begin
            next_state = RESET_PLL;
            retry_next = '0;
          end
        end
        FAULT:   next_state = FAULT;
        default: next_state = RESET_PLL;
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered copy lines up with state.
  always_comb begin
    pll_areset_d = (next_state == RESET_PLL) || (next_state == FAULT);
    sys_reset_d  = (next_state != RUN);
    ready_d      = (next_state == RUN);
    fault_d      = (next_state == FAULT);
  end

  always_ff @(posedge inclk0) begin
    if (reset) begin
      state       <= RESET_PLL;
      rst_cnt     <= '0;
      stable_cnt  <= '0;
      to_cnt      <= '0;
      retry_count <= '0;
      pll_areset  <= 1'b1;
      sys_reset   <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= next_state;
      retry_count <= retry_next;
      pll_areset  <= pll_areset_d;
      sys_reset   <= sys_reset_d;
      ready       <= ready_d;
      fault       <= fault_d;

      rst_cnt    <= (!restart && state == RESET_PLL && next_state == RESET_PLL)
                    ? rst_cnt + 1'b1 : '0;
      stable_cnt <= (state == STABLE && next_state == STABLE) ? stable_cnt + 1'b1 : '0;

      // Timeout spans the whole attempt: it keeps running through STABLE and back.
      if ((next_state == WAIT_LOCK || next_state == STABLE) && state != RESET_PLL) begin
        if (to_cnt != TO_LAST) to_cnt <= to_cnt + 1'b1;
      end else begin
        to_cnt <= '0;
      end
    end
  end

`ifdef PLL_SEQ_LOSS_COUNT_EN
  always_ff @(posedge inclk0) begin
    if (reset) begin
      lock_loss_count <= '0;
    end else if (state == RUN && !lock_s && !restart && lock_loss_count != 8'hff) begin
      lock_loss_count <= lock_loss_count + 1'b1;
    end
  end
`endif

endmodule
